uart_line_buffer: RTL and testbench

- Byte-stream line assembler that sits between the cpu_sim_uart receive side (data_o/data_valid_o) and a bus-side or bench-side consumer.
- Buffers characters in a FIFO and releases them only as complete lines, each closed by a terminator character.
- Discards partial lines on inactivity timeout or on FIFO overflow.
- Parametrised in data width, depth, terminator and timeout. It replaces ad-hoc newline polling and gives per-line framing in hardware.

---
 rtl/uart_line_buffer.sv | 185 ++++++++++++++++++
 tb/tb_uart_line_buffer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_buffer.sv
// uart_line_buffer: buffers a received character stream and releases it as terminator-closed lines.
// Optional macro UART_LINE_BUFFER_STRIP_CR_EN drops 'h0D characters at the write port.
module uart_line_buffer #(
    parameter int unsigned          DataWidth     = 8,
    parameter int unsigned          Depth         = 64,
    parameter logic [DataWidth-1:0] Terminator    = 'h0A,
    parameter int unsigned          TimeoutCycles = 500000
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [DataWidth-1:0]   data_i,
    input  logic                   data_valid_i,
    output logic                   data_ready_o,
    input  logic                   flush_i,
    output logic [DataWidth-1:0]   rd_data_o,
    output logic                   rd_last_o,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output logic [$clog2(Depth):0] line_count_o,
    output logic                   overflow_o,
    output logic                   timeout_o
);
    localparam int unsigned PtrW    = $clog2(Depth);
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned IdleW   = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam int unsigned IdleMax = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;

    typedef enum logic [1:0] {IDLE, FILL, DROP} state_e;

    state_e              state_q, state_d;
    logic [DataWidth:0]  mem_q [Depth];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     line_start_q, line_start_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [CntW-1:0]     part_len_q, part_len_d;
    logic [CntW-1:0]     line_cnt_q, line_cnt_d;
    logic [IdleW-1:0]    idle_q, idle_d;
    logic                overflow_q, overflow_d;
    logic                timeout_q, timeout_d;

    logic               full, pop, pop_last, is_term, is_cr, wr_req;
    logic               wr_en, commit, rewind;
    logic [DataWidth:0] head;

    always_comb begin
        head       = mem_q[rd_ptr_q];
        full       = (count_q == CntW'(Depth));
        rd_valid_o = (line_cnt_q != '0);
        pop        = rd_valid_o && rd_ready_i;
        pop_last   = pop && head[DataWidth];
        is_term    = (data_i == Terminator);
`ifdef UART_LINE_BUFFER_STRIP_CR_EN
        is_cr      = (data_i == DataWidth'('h0D));
`else
        is_cr      = 1'b0;
`endif
        wr_req     = data_valid_i && !is_cr;

        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        line_start_d = line_start_q;
        part_len_d   = part_len_q;
        idle_d       = idle_q;
        overflow_d   = 1'b0;
        timeout_d    = 1'b0;
        wr_en        = 1'b0;
        commit       = 1'b0;
        rewind       = 1'b0;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (state_q)
            IDLE, FILL: begin
                if (wr_req) begin
                    // A same-cycle pop frees the slot, so a full FIFO still accepts.
                    if (!full || pop) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (is_term) begin
                            commit       = 1'b1;
                            line_start_d = wr_ptr_q + 1'b1;
                            part_len_d   = '0;
                            state_d      = IDLE;
                        end else begin
                            part_len_d = part_len_q + 1'b1;
                            state_d    = FILL;
                        end
                    end else begin
                        rewind     = 1'b1;
                        overflow_d = 1'b1;
                        state_d    = is_term ? IDLE : DROP;
                    end
                end
            end
            DROP: begin
                if (wr_req && is_term) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (data_valid_i || state_q != FILL) begin
            idle_d = '0;
        end else if (TimeoutCycles != 0) begin
            if (idle_q == IdleW'(IdleMax)) begin
                rewind    = 1'b1;
                timeout_d = 1'b1;
                state_d   = IDLE;
                idle_d    = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end

        // Rewind only discards the partial line; committed entries sit before line_start.
        if (rewind) begin
            wr_ptr_d   = line_start_q;
            part_len_d = '0;
        end

        count_d    = count_q + CntW'(wr_en) - CntW'(pop) - (rewind ? part_len_q : '0);
        line_cnt_d = line_cnt_q + CntW'(commit) - CntW'(pop_last);

        if (flush_i) begin
            state_d      = IDLE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            line_start_d = '0;
            part_len_d   = '0;
            count_d      = '0;
            line_cnt_d   = '0;
            idle_d       = '0;
            overflow_d   = 1'b0;
            timeout_d    = 1'b0;
            wr_en        = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {is_term, data_i};
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            line_start_q <= '0;
            part_len_q   <= '0;
            count_q      <= '0;
            line_cnt_q   <= '0;
            idle_q       <= '0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            line_start_q <= line_start_d;
            part_len_q   <= part_len_d;
            count_q      <= count_d;
            line_cnt_q   <= line_cnt_d;
            idle_q       <= idle_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        rd_data_o    = (count_q != '0) ? head[DataWidth-1:0] : '0;
        rd_last_o    = (count_q != '0) && head[DataWidth];
        data_ready_o = !full || (state_q == DROP);
        line_count_o = line_cnt_q;
        overflow_o   = overflow_q;
        timeout_o    = timeout_q;
    end

endmodule

// File: tb/tb_uart_line_buffer.sv
// Bench for uart_line_buffer: table vectors, directed line sequences and random traffic
// checked every cycle against a queue-based model of the line-buffer rules.
module tb_uart_line_buffer;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int TMO   = 100;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] TERM = 8'h0A;
    localparam logic [DW-1:0] CR   = 8'h0D;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          data_valid_i = 1'b0;
    logic          data_ready_o;
    logic          flush_i = 1'b0;
    logic [DW-1:0] rd_data_o;
    logic          rd_last_o;
    logic          rd_valid_o;
    logic          rd_ready_i = 1'b0;
    logic [CW-1:0] line_count_o;
    logic          overflow_o;
    logic          timeout_o;

    uart_line_buffer #(
        .DataWidth(DW), .Depth(DEPTH), .Terminator(TERM), .TimeoutCycles(TMO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .data_valid_i(data_valid_i),
        .data_ready_o(data_ready_o), .flush_i(flush_i), .rd_data_o(rd_data_o),
        .rd_last_o(rd_last_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .line_count_o(line_count_o), .overflow_o(overflow_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: committed characters, the pending partial line, and a drop flag.
    logic [DW-1:0] m_commit[$];
    logic [DW-1:0] m_part[$];
    bit m_drop;
    int m_idle;
    bit m_ovf, m_to;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_lines();
        int n = 0;
        foreach (m_commit[i]) if (m_commit[i] == TERM) n++;
        return n;
    endfunction

    function automatic void m_clear();
        m_commit.delete();
        m_part.delete();
        m_drop = 0;
        m_idle = 0;
        m_ovf  = 0;
        m_to   = 0;
    endfunction

    function automatic void m_update(bit v, logic [DW-1:0] d, bit rr, bit fl);
        bit pop, space, is_cr;
        m_ovf = 0;
        m_to  = 0;
        if (fl) begin
            m_clear();
            return;
        end
        is_cr = 0;
`ifdef UART_LINE_BUFFER_STRIP_CR_EN
        is_cr = (d == CR);
`endif
        pop   = (m_lines() != 0) && rr;
        space = (m_commit.size() + m_part.size() < DEPTH) || pop;
        if (pop) void'(m_commit.pop_front());
        if (v && !is_cr) begin
            if (m_drop) begin
                if (d == TERM) m_drop = 0;
            end else if (space) begin
                if (d == TERM) begin
                    foreach (m_part[i]) m_commit.push_back(m_part[i]);
                    m_part.delete();
                    m_commit.push_back(d);
                end else begin
                    m_part.push_back(d);
                end
            end else begin
                m_ovf = 1;
                m_part.delete();
                if (d != TERM) m_drop = 1;
            end
        end
        if (v || m_part.size() == 0) begin
            m_idle = 0;
        end else if (m_idle == TMO - 1) begin
            m_part.delete();
            m_to   = 1;
            m_idle = 0;
        end else begin
            m_idle++;
        end
    endfunction

    task automatic m_check();
        logic [DW-1:0] head;
        int occ;
        occ  = m_commit.size() + m_part.size();
        head = (m_commit.size() != 0) ? m_commit[0] : ((m_part.size() != 0) ? m_part[0] : '0);
        chk("m_rd_valid", rd_valid_o, m_lines() != 0);
        chk("m_line_count", line_count_o, m_lines());
        chk("m_rd_data", rd_data_o, head);
        chk("m_rd_last", rd_last_o, (occ != 0) && (head == TERM));
        chk("m_data_ready", data_ready_o, m_drop || (occ < DEPTH));
        chk("m_overflow", overflow_o, m_ovf);
        chk("m_timeout", timeout_o, m_to);
    endtask

    // Called at posedge+1: drive, compare current outputs with the model, advance one cycle.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit rr, input bit fl);
        data_valid_i = v;
        data_i       = d;
        rd_ready_i   = rr;
        flush_i      = fl;
        m_check();
        m_update(v, d, rr, fl);
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_str(input string s, input bit rr);
        for (int i = 0; i < s.len(); i++) step(1, s[i], rr, 0);
    endtask

    task automatic drain(input string exp, input string nm);
        int k = 0;
        while (rd_valid_o && k < 40) begin
            if (k < exp.len()) begin
                chk({nm, "_char"}, rd_data_o, exp[k]);
                chk({nm, "_last"}, rd_last_o, exp[k] == TERM);
            end
            step(0, '0, 1, 0);
            k++;
        end
        chk({nm, "_len"}, k, exp.len());
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ready"}, data_ready_o, 1);
        chk({nm, "_rd_valid"}, rd_valid_o, 0);
        chk({nm, "_rd_data"}, rd_data_o, 0);
        chk({nm, "_rd_last"}, rd_last_o, 0);
        chk({nm, "_lines"}, line_count_o, 0);
        chk({nm, "_ovf"}, overflow_o, 0);
        chk({nm, "_tmo"}, timeout_o, 0);
    endtask

    typedef struct {
        bit v; logic [7:0] d; bit rr; bit fl;
        int lc; bit rv; bit last; logic [7:0] data;
    } vec_t;

    initial begin
        vec_t tbl[13];
        int pulses;
        string exp_cr;

        tbl[0]  = '{0, 8'h00, 0, 1, 0, 0, 0, 8'h00};
        tbl[1]  = '{1, 8'h0A, 0, 0, 1, 1, 1, 8'h0A};
        tbl[2]  = '{1, 8'h0A, 0, 0, 2, 1, 1, 8'h0A};
        tbl[3]  = '{1, 8'h0A, 0, 0, 3, 1, 1, 8'h0A};
        tbl[4]  = '{0, 8'h00, 1, 0, 2, 1, 1, 8'h0A};
        tbl[5]  = '{1, 8'h61, 0, 0, 2, 1, 1, 8'h0A};
        tbl[6]  = '{1, 8'h0A, 1, 0, 2, 1, 1, 8'h0A};
        tbl[7]  = '{0, 8'h00, 1, 0, 1, 1, 0, 8'h61};
        tbl[8]  = '{0, 8'h00, 1, 0, 1, 1, 1, 8'h0A};
        tbl[9]  = '{1, 8'h62, 0, 0, 1, 1, 1, 8'h0A};
        tbl[10] = '{1, 8'h0A, 0, 0, 2, 1, 1, 8'h0A};
        tbl[11] = '{1, 8'h63, 1, 1, 0, 0, 0, 8'h00};
        tbl[12] = '{0, 8'h00, 0, 0, 0, 0, 0, 8'h00};

        m_clear();
        #2;
        chk_reset_outputs("reset");
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].rr, tbl[i].fl);
            chk("tbl_lines", line_count_o, tbl[i].lc);
            chk("tbl_rd_valid", rd_valid_o, tbl[i].rv);
            chk("tbl_rd_last", rd_last_o, tbl[i].last);
            chk("tbl_rd_data", rd_data_o, tbl[i].data);
        end

        begin
            string line = "readFPGAVersion\n";
            step(0, '0, 0, 1);
            for (int i = 0; i < 15; i++) begin
                step(1, line[i], 1, 0);
                chk("ver_hidden", rd_valid_o, 0);
            end
            step(1, line[15], 1, 0);
            chk("ver_valid", rd_valid_o, 1);
            chk("ver_lines1", line_count_o, 1);
            drain(line, "ver");
            chk("ver_lines0", line_count_o, 0);
        end

        step(0, '0, 0, 1);
        write_str("ab", 0);
        pulses = 0;
        for (int k = 0; k < 120; k++) begin
            step(0, '0, 0, 0);
            if (timeout_o) pulses++;
        end
        chk("tmo_pulses", pulses, 1);
        chk("tmo_lines", line_count_o, 0);
        write_str("cd\n", 0);
        drain("cd\n", "tmo_read");

        begin
            string ov = "ABCDEFGH\n";
            step(0, '0, 0, 1);
            write_str("0123456789\n", 0);
            for (int i = 0; i < ov.len(); i++) begin
                step(1, ov[i], 0, 0);
                chk("ovf_pulse", overflow_o, i == 5);
                if (i == 4) chk("ovf_full_ready", data_ready_o, 0);
                if (i == 5) chk("ovf_drop_ready", data_ready_o, 1);
            end
            chk("ovf_lines", line_count_o, 1);
            drain("0123456789\n", "ovf_read");
            chk("ovf_empty", rd_valid_o, 0);
        end

        step(0, '0, 0, 1);
        write_str("x\r\n", 0);
`ifdef UART_LINE_BUFFER_STRIP_CR_EN
        exp_cr = "x\n";
`else
        exp_cr = "x\r\n";
`endif
        drain(exp_cr, "cr");

        write_str("pq", 0);
        reset_i = 1'b0;
        #2;
        chk_reset_outputs("midreset");
        m_clear();
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        for (int k = 0; k < 110; k++) step(0, '0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [DW-1:0] d;
            if ($urandom_range(0, 199) == 0) begin
                for (int k = 0; k < 110; k++) step(0, '0, $urandom_range(0, 1) == 1, 0);
            end
            r = $urandom_range(0, 9);
            d = (r < 2) ? TERM : ((r == 2) ? CR : DW'($urandom_range(8'h41, 8'h5A)));
            step($urandom_range(0, 99) < 45, d, $urandom_range(0, 99) < 30, $urandom_range(0, 299) == 0);
        end
        m_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
